// File: rtl/mips_pkg.sv
// Shared types for the MIPS hazard controller.
// Memory-wait FSM states, forward selects, forward helper.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HUNG
  } mw_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M result is youngest, so it beats W.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] wr_m,
    input logic       we_m,
    input logic [4:0] wr_w,
    input logic       we_w
  );
    logic hit_m;
    logic hit_w;
    hit_m = (rs != 5'd0) && (rs == wr_m) && we_m;
    hit_w = (rs != 5'd0) && (rs == wr_w) && we_w;
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Memory-access handshake between hazard logic and wait FSM.
// master: hazard logic; slave: mem_wait_fsm.
interface hazard_ctrl_if;
  logic memacc;
  logic mem_ready;
  logic memstall;
  logic mem_err;

  modport master (
    output memacc,
    output mem_ready,
    input  memstall,
    input  mem_err
  );

  modport slave (
    input  memacc,
    input  mem_ready,
    output memstall,
    output mem_err
  );
endinterface

// File: rtl/mem_wait_fsm.sv
// Sequences multi-cycle data-memory accesses.
// Waits on mem_ready; hangs after TIMEOUT wait cycles.
module mem_wait_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave mb
);

  localparam logic [15:0] TO_W = 16'(TIMEOUT);

  mw_state_e   state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        memstall;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    memstall = 1'b0;
    unique case (state_q)
      IDLE: begin
        memstall = mb.memacc & ~mb.mem_ready;
        if (memstall) begin
          state_d = WAIT;
          wcnt_d  = 16'd1;
        end
      end
      WAIT: begin
        memstall = ~mb.mem_ready;
        // ready beats the timeout on the same cycle
        if (mb.mem_ready) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == TO_W) begin
          state_d = HUNG;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      HUNG: begin
        memstall = 1'b1;
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign mb.memstall = memstall;
  assign mb.mem_err  = (state_q == HUNG);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Forwarding, stall/flush generation and perf counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             mem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_ctrl_if mb ();

  assign mb.memacc    = MemtoRegM | MemWriteM;
  assign mb.mem_ready = mem_ready;

  mem_wait_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait_fsm (
    .clk   (clk),
    .reset (reset),
    .mb    (mb.slave)
  );

  assign mem_err = mb.mem_err;

  logic             lwstall;
  logic             brstall;
  logic             memstall;
  logic             hz;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    lwstall = MemtoRegE
            & ((RtE == RsD) | (RtE == RtD));
    brstall = BranchD
            & ((RegWriteE
                & ((WriteRegE == RsD)
                 | (WriteRegE == RtD)))
             | (MemtoRegM
                & ((WriteRegM == RsD)
                 | (WriteRegM == RtD))));
    memstall = mb.memstall;
    hz       = lwstall | brstall;
  end

  // Reset forces a quiet pipeline: no stalls, bubbles everywhere.
  always_comb begin
    StallF    = ~reset & (hz | memstall);
    StallD    = StallF;
    StallE    = ~reset & memstall;
    StallM    = StallE;
    StallW    = StallE;
    FlushE    = reset | (hz & ~memstall);
    FlushD    = reset | (PCSrcD & ~StallD);
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM,
                          WriteRegW, RegWriteW);
      ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM,
                          WriteRegW, RegWriteW);
      ForwardAD = (RsD != 5'd0) & (RsD == WriteRegM)
                & RegWriteM;
      ForwardBD = (RtD != 5'd0) & (RtD == WriteRegM)
                & RegWriteM;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(StallF);
    flush_cnt_d = flush_cnt_q + CNT_W'(FlushD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl.
// Stimulus pushes expected outputs; a negedge monitor compares.
module tb_hazard_ctrl;
  import mips_pkg::*;

  localparam int TO = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [4:0]    RsD = 0, RtD = 0, RsE = 0, RtE = 0;
  logic [4:0]    WriteRegE = 0, WriteRegM = 0, WriteRegW = 0;
  logic          RegWriteE = 0, RegWriteM = 0, RegWriteW = 0;
  logic          MemtoRegE = 0, MemtoRegM = 0, MemWriteM = 0;
  logic          BranchD = 0, PCSrcD = 0;
  logic          StallF, StallD, StallE, StallM, StallW;
  logic          FlushD, FlushE, ForwardAD, ForwardBD;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl_if mb ();
  assign mb.memacc   = MemtoRegM | MemWriteM;
  assign mb.memstall = StallE;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
    .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM),
    .BranchD(BranchD), .PCSrcD(PCSrcD),
    .mem_ready(mb.mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mb.mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [4:0]    stall;
    logic [1:0]    flush;
    logic [1:0]    fwd_d;
    logic [3:0]    fwd_e;
    logic          err;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state, in terms of the access, not the FSM.
  bit      m_hung = 0;
  bit      m_busy = 0;
  int      m_k    = 0;
  int      m_sc   = 0;
  int      m_fc   = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] r);
    if (r == 0)                          return 2'b00;
    if (RegWriteM && r == WriteRegM)     return 2'b10;
    if (RegWriteW && r == WriteRegW)     return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit reads_d(input logic [4:0] r);
    return (r == RsD) || (r == RtD);
  endfunction

  task automatic model_step();
    exp_t e;
    bit lw, br, ms, sf, fd;
    lw = MemtoRegE && reads_d(RtE);
    br = BranchD && ((RegWriteE && reads_d(WriteRegE))
                  || (MemtoRegM && reads_d(WriteRegM)));
    if (m_hung)      ms = 1;
    else if (m_busy) ms = !mb.mem_ready;
    else             ms = (MemtoRegM || MemWriteM) && !mb.mem_ready;
    sf = !reset && (lw || br || ms);
    fd = reset || (PCSrcD && !sf);
    e.stall = {sf, sf, {3{!reset && ms}}};
    e.flush = {fd, reset || ((lw || br) && !ms)};
    if (reset) begin
      e.fwd_d = 2'b00;
      e.fwd_e = 4'b0000;
    end else begin
      e.fwd_d = {ref_fwd(RsD) == 2'b10, ref_fwd(RtD) == 2'b10};
      e.fwd_e = {ref_fwd(RsE), ref_fwd(RtE)};
    end
    e.err = m_hung;
    e.sc  = CW'(m_sc);
    e.fc  = CW'(m_fc);
    sb.push_back(e);
    if (reset) begin
      m_hung = 0; m_busy = 0; m_k = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_sc = (m_sc + int'(sf)) % (1 << CW);
      m_fc = (m_fc + int'(fd)) % (1 << CW);
      if (!m_hung) begin
        if (ms) begin
          m_k++;
          m_busy = 1;
          if (m_k == TO + 1) m_hung = 1;
        end else begin
          m_busy = 0;
          m_k = 0;
        end
      end
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet();
    reset = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; MemWriteM = 0;
    BranchD = 0; PCSrcD = 0; mb.mem_ready = 1;
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stalls", 32'({StallF, StallD, StallE, StallM, StallW}),
          32'(e.stall));
      chk("flushes", 32'({FlushD, FlushE}), 32'(e.flush));
      chk("fwd_d", 32'({ForwardAD, ForwardBD}), 32'(e.fwd_d));
      chk("fwd_e", 32'({ForwardAE, ForwardBE}), 32'(e.fwd_e));
      chk("mem_err", 32'(mb.mem_err), 32'(e.err));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
    end
  end

  initial begin
    mb.mem_ready = 1;
    @(posedge clk);
    #1;
    quiet(); reset = 1; tick(2);
    // forwarding from M, then $0, then W, then M beats W
    quiet(); WriteRegM = 3; RsE = 3; RegWriteM = 1; tick();
    RsE = 0; tick();
    quiet(); WriteRegW = 4; RegWriteW = 1; RtE = 4; tick();
    WriteRegM = 4; RegWriteM = 1; RsE = 4; tick();
    // load-use
    quiet(); MemtoRegE = 1; RtE = 5; WriteRegE = 5; RsD = 5;
    tick();
    quiet(); tick();
    // taken branch depending on ALU op in E, then released
    quiet(); BranchD = 1; PCSrcD = 1; RsD = 7;
    RegWriteE = 1; WriteRegE = 7; tick();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 7;
    tick();
    // 3-wait load in M, with a coincident load-use
    quiet(); MemtoRegM = 1; WriteRegM = 9;
    MemtoRegE = 1; RtE = 2; RsD = 2;
    mb.mem_ready = 0; tick(3);
    mb.mem_ready = 1; tick();
    quiet(); tick();
    // store: ready arrives exactly when wait reaches TIMEOUT
    quiet(); MemWriteM = 1; mb.mem_ready = 0; tick(TO);
    mb.mem_ready = 1; tick();
    quiet(); tick();
    // hang, long enough for the stall counter to wrap
    quiet(); MemtoRegM = 1; mb.mem_ready = 0; tick(8);
    mb.mem_ready = 1; tick(300);
    reset = 1; tick();
    quiet(); tick(2);
    // reset in the middle of a wait
    quiet(); MemWriteM = 1; PCSrcD = 1; mb.mem_ready = 0; tick(2);
    reset = 1; tick();
    quiet(); tick(2);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 60) == 0);
      RsD          = 5'($urandom_range(0, 3));
      RtD          = 5'($urandom_range(0, 3));
      RsE          = 5'($urandom_range(0, 3));
      RtE          = 5'($urandom_range(0, 3));
      WriteRegE    = 5'($urandom_range(0, 3));
      WriteRegM    = 5'($urandom_range(0, 3));
      WriteRegW    = 5'($urandom_range(0, 3));
      RegWriteE    = 1'($urandom);
      RegWriteM    = 1'($urandom);
      RegWriteW    = 1'($urandom);
      MemtoRegE    = ($urandom_range(0, 3) == 0);
      MemtoRegM    = ($urandom_range(0, 3) == 0);
      MemWriteM    = ($urandom_range(0, 5) == 0);
      BranchD      = 1'($urandom);
      PCSrcD       = 1'($urandom);
      mb.mem_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    quiet(); reset = 1; tick();
    quiet(); tick(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It drives the stall, flush and forwarding selects for the F/D, D/E, E/M and M/W pipeline registers, replacing the hard-wired `stallD = 0`. It also sequences multi-cycle data-memory accesses through a ready handshake, with a timeout watchdog and stall/flush performance counters.

## Interface
Parameters:
- `TIMEOUT`, 255: wait cycles before a data-memory access is declared hung; legal range 1 to 2^16−1.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk` in 1: the single clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `RsD`, `RtD` in 5: source register numbers in Decode.
- `RsE`, `RtE` in 5: source register numbers in Execute.
- `WriteRegE`, `WriteRegM`, `WriteRegW` in 5: destination register numbers in E, M and W.
- `RegWriteE`, `RegWriteM`, `RegWriteW` in 1: register write enables in E, M and W.
- `MemtoRegE`, `MemtoRegM` in 1: a load is in E or in M.
- `MemWriteM` in 1: a store is in M.
- `BranchD` in 1: a branch is in Decode.
- `PCSrcD` in 1: the branch in Decode resolved taken.
- `mem_ready` in 1: data memory has completed the access presented in M.
- `StallF`, `StallD`, `StallE`, `StallM`, `StallW` out 1: hold the corresponding pipeline register.
- `FlushD`, `FlushE` out 1: clear the F/D and D/E registers to a bubble.
- `ForwardAD`, `ForwardBD` out 1: select the M-stage result for the Decode branch comparator.
- `ForwardAE`, `ForwardBE` out 2: Execute operand select. 00 = register file, 01 = W result, 10 = M result.
- `mem_err` out 1: sticky flag, set on memory timeout.
- `stall_cnt` out CNT_W: number of cycles with StallF high.
- `flush_cnt` out CNT_W: number of cycles with FlushD high.

## Operation
Forwarding (combinational):
- `ForwardAE` = 10 if `RsE`≠0 and `RsE`=`WriteRegM` and `RegWriteM`.
- Otherwise `ForwardAE` = 01 if `RsE`≠0 and `RsE`=`WriteRegW` and `RegWriteW`.
- Otherwise `ForwardAE` = 00.
- `ForwardBE` follows the same rules using `RtE`.
- `ForwardAD` = `RsD`≠0 and `RsD`=`WriteRegM` and `RegWriteM`. `ForwardBD` uses `RtD` the same way.

Hazard terms:
- `lwstall` = `MemtoRegE` and (`RtE`=`RsD` or `RtE`=`RtD`).
- `brstall` = `BranchD` and one of:
  - `RegWriteE` and `WriteRegE` ∈ {`RsD`, `RtD`};
  - `MemtoRegM` and `WriteRegM` ∈ {`RsD`, `RtD`}.
- `memacc` = `MemtoRegM` or `MemWriteM`.

Memory-wait FSM, states IDLE, WAIT, HUNG:
- IDLE:
  - `memstall` = `memacc` and not `mem_ready`.
  - If `memstall`, go to WAIT and set `wcnt` = 1.
- WAIT:
  - `memstall` = not `mem_ready`.
  - If `mem_ready`, go to IDLE and clear `wcnt`.
  - Else if `wcnt`=`TIMEOUT`, go to HUNG.
  - Else increment `wcnt`.
- HUNG: `memstall` = 1; `mem_err` = 1. The state is left only by `reset`.

Outputs:
- `StallF` = `StallD` = `lwstall` or `brstall` or `memstall`.
- `StallE` = `StallM` = `StallW` = `memstall`.
- `FlushE` = (`lwstall` or `brstall`) and not `memstall`.
- `FlushD` = `PCSrcD` and not `StallD`. A taken branch is never flushed while it is held.
- `stall_cnt` increments on each cycle with `StallF`=1; `flush_cnt` increments on each cycle with `FlushD`=1. Both wrap modulo 2^CNT_W.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the FSM state, with zero-cycle latency.
- A 0-wait memory access (`mem_ready` high in the first M cycle) causes no stall. An access that waits N cycles stalls for exactly N cycles.
- In WAIT, if `mem_ready` rises in the same cycle that `wcnt` reaches `TIMEOUT`, the ready wins and the FSM returns to IDLE.
- When `memstall` and `lwstall` coincide, the memory stall holds every stage and no bubble is inserted. The load-use stall is re-evaluated on the first cycle after `memstall` drops.
- While `reset`=1:
  - All stalls are 0; `FlushD` = `FlushE` = 1; all forwards are 0.
  - On the reset edge, the FSM goes to IDLE, and `wcnt`, `mem_err`, `stall_cnt` and `flush_cnt` are cleared to 0.
- A `reset` asserted during WAIT or HUNG takes effect on the next edge, with no completion of the pending access.

## Structure
- `mips_pkg` holds:
  - the FSM state type (IDLE/WAIT/HUNG);
  - the forward-select constants `FWD_RF`=00, `FWD_W`=01, `FWD_M`=10.
- Sub-module `mem_wait_fsm` contains the state register, `wcnt` (16 bits), `memstall` and `mem_err`.
- The top level contains the forwarding logic, the hazard terms, the output logic and the two performance counters.

## Test plan
- Two back-to-back `add` instructions writing and then reading $3 (`WriteRegM`=3, `RsE`=3, `RegWriteM`=1) → `ForwardAE`=10, no stall. Repeat with `RsE`=0 → `ForwardAE`=00.
- A load to $5 in E with `RsD`=5 → one cycle of `StallF`=`StallD`=`FlushE`=1; `stall_cnt` goes from 0 to 1.
- A taken branch in D (`PCSrcD`=1) whose source is written by an ALU op in E → cycle 1: `StallD`=1, `FlushD`=0, `FlushE`=1. Next cycle: `FlushD`=1 and `flush_cnt`=1.
- A load in M with `mem_ready` low for 3 cycles → all five stalls high for exactly 3 cycles, `FlushE`=0, then return to IDLE.
- `TIMEOUT`=4 and `mem_ready` held low → HUNG after the 4th WAIT cycle, `mem_err`=1, stalls held high. Asserting `reset` returns the FSM to IDLE and clears `mem_err`.
- `reset` asserted mid-WAIT → next cycle: state IDLE, `wcnt`=0, both counters 0, `FlushD`=`FlushE`=1 during the reset cycle.
